cmd_frame_ctrl: RTL and testbench

CMD_FRAME_CTRL -- requirements
Module: cmd_frame_ctrl

---
 rtl/cmd_frame_ctrl_if.sv | 40 ++++
 rtl/cmd_frame_ctrl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_cmd_frame_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_frame_ctrl_if.sv
// Bus bundle for cmd_frame_ctrl: RX byte stream, register-file, ALU and TX FIFO signals.
// master = the frame controller, slave = the surrounding system.
`timescale 1ns/1ps
interface cmd_frame_ctrl_if #(
    parameter int Data_width    = 8,
    parameter int Address_width = 4,
    parameter int ALU_OUT_BYTES = 2
);
    logic [Data_width-1:0]               RX_p_data;
    logic                                RX_d_valid;
    logic [ALU_OUT_BYTES*Data_width-1:0] ALU_OUT;
    logic                                OUT_VALID;
    logic [Data_width-1:0]               Rd_data;
    logic                                RdData_valid;
    logic                                FIFO_full;

    logic                                ALU_EN;
    logic [3:0]                          ALU_FUN;
    logic                                CLK_EN;
    logic [Address_width-1:0]            Address;
    logic                                WrEN;
    logic                                RdEN;
    logic [Data_width-1:0]               WrData;
    logic [Data_width-1:0]               TX_p_data;
    logic                                TX_d_valid;
    logic                                clk_div_en;
    logic                                cmd_err;

    modport master (
        input  RX_p_data, RX_d_valid, ALU_OUT, OUT_VALID, Rd_data, RdData_valid, FIFO_full,
        output ALU_EN, ALU_FUN, CLK_EN, Address, WrEN, RdEN, WrData,
               TX_p_data, TX_d_valid, clk_div_en, cmd_err
    );

    modport slave (
        output RX_p_data, RX_d_valid, ALU_OUT, OUT_VALID, Rd_data, RdData_valid, FIFO_full,
        input  ALU_EN, ALU_FUN, CLK_EN, Address, WrEN, RdEN, WrData,
               TX_p_data, TX_d_valid, clk_div_en, cmd_err
    );
endinterface

// File: rtl/cmd_frame_ctrl.sv
// Command-frame controller: decodes RX byte frames into register, ALU and TX FIFO traffic.
// Define CMD_FRAME_BURST_EN to compile in the burst write (0xEE) / burst read (0xEF) commands.
`timescale 1ns/1ps
module cmd_frame_ctrl #(
    parameter int Data_width    = 8,
    parameter int Address_width = 4,
    parameter int ALU_OUT_BYTES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    cmd_frame_ctrl_if.master bus
);
    localparam int BUF_W = ALU_OUT_BYTES * Data_width;

    localparam logic [Data_width-1:0] OP_WR     = Data_width'(8'hAA);
    localparam logic [Data_width-1:0] OP_RD     = Data_width'(8'hBB);
    localparam logic [Data_width-1:0] OP_ALU_OP = Data_width'(8'hCC);
    localparam logic [Data_width-1:0] OP_ALU_NO = Data_width'(8'hDD);
`ifdef CMD_FRAME_BURST_EN
    localparam logic [Data_width-1:0] OP_BWR    = Data_width'(8'hEE);
    localparam logic [Data_width-1:0] OP_BRD    = Data_width'(8'hEF);
`endif

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
        ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_SEND
`ifdef CMD_FRAME_BURST_EN
        , BR_ADDR, BR_LEN, BW_DATA, BR_ISSUE
`endif
    } state_t;

    state_t                   state_reg, state_next;
    logic [Address_width-1:0] address_reg, address_next;
    logic                     wr_en_reg, wr_en_next;
    logic [Data_width-1:0]    wr_data_reg, wr_data_next;
    logic                     rd_en_reg, rd_en_next;
    logic                     alu_en_reg, alu_en_next;
    logic [3:0]               alu_fun_reg, alu_fun_next;
    logic                     clk_en_reg, clk_en_next;
    logic                     cmd_err_reg, cmd_err_next;
    logic [BUF_W-1:0]         tx_buf_reg, tx_buf_next;
    logic [2:0]               tx_cnt_reg, tx_cnt_next;
`ifdef CMD_FRAME_BURST_EN
    logic [Data_width-1:0]    burst_cnt_reg, burst_cnt_next;
    logic                     burst_wr_reg, burst_wr_next;
    logic                     burst_rd_reg, burst_rd_next;
    logic                     first_reg, first_next;
`endif

    logic tx_fire;
    assign tx_fire = (state_reg == TX_SEND) && !bus.FIFO_full;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg     <= IDLE;
            address_reg   <= '0;
            wr_en_reg     <= 1'b0;
            wr_data_reg   <= '0;
            rd_en_reg     <= 1'b0;
            alu_en_reg    <= 1'b0;
            alu_fun_reg   <= '0;
            clk_en_reg    <= 1'b0;
            cmd_err_reg   <= 1'b0;
            tx_buf_reg    <= '0;
            tx_cnt_reg    <= '0;
`ifdef CMD_FRAME_BURST_EN
            burst_cnt_reg <= '0;
            burst_wr_reg  <= 1'b0;
            burst_rd_reg  <= 1'b0;
            first_reg     <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            address_reg   <= address_next;
            wr_en_reg     <= wr_en_next;
            wr_data_reg   <= wr_data_next;
            rd_en_reg     <= rd_en_next;
            alu_en_reg    <= alu_en_next;
            alu_fun_reg   <= alu_fun_next;
            clk_en_reg    <= clk_en_next;
            cmd_err_reg   <= cmd_err_next;
            tx_buf_reg    <= tx_buf_next;
            tx_cnt_reg    <= tx_cnt_next;
`ifdef CMD_FRAME_BURST_EN
            burst_cnt_reg <= burst_cnt_next;
            burst_wr_reg  <= burst_wr_next;
            burst_rd_reg  <= burst_rd_next;
            first_reg     <= first_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        address_next   = address_reg;
        wr_en_next     = 1'b0;
        wr_data_next   = wr_data_reg;
        rd_en_next     = 1'b0;
        alu_en_next    = 1'b0;
        alu_fun_next   = alu_fun_reg;
        clk_en_next    = clk_en_reg;
        cmd_err_next   = 1'b0;
        tx_buf_next    = tx_buf_reg;
        tx_cnt_next    = tx_cnt_reg;
`ifdef CMD_FRAME_BURST_EN
        burst_cnt_next = burst_cnt_reg;
        burst_wr_next  = burst_wr_reg;
        burst_rd_next  = burst_rd_reg;
        first_next     = first_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (bus.RX_d_valid) begin
                    case (bus.RX_p_data)
                        OP_WR:     state_next = WR_ADDR;
                        OP_RD:     state_next = RD_ADDR;
                        OP_ALU_OP: state_next = ALU_A;
                        OP_ALU_NO: state_next = ALU_FUN;
`ifdef CMD_FRAME_BURST_EN
                        OP_BWR: begin
                            burst_wr_next = 1'b1;
                            state_next    = BR_ADDR;
                        end
                        OP_BRD: begin
                            burst_wr_next = 1'b0;
                            state_next    = BR_ADDR;
                        end
`endif
                        default:   cmd_err_next = 1'b1;
                    endcase
                end
            end
            WR_ADDR: begin
                if (bus.RX_d_valid) begin
                    address_next = bus.RX_p_data[Address_width-1:0];
                    state_next   = WR_DATA;
                end
            end
            WR_DATA: begin
                if (bus.RX_d_valid) begin
                    wr_en_next   = 1'b1;
                    wr_data_next = bus.RX_p_data;
                    state_next   = IDLE;
                end
            end
            RD_ADDR: begin
                if (bus.RX_d_valid) begin
                    address_next = bus.RX_p_data[Address_width-1:0];
                    rd_en_next   = 1'b1;
                    state_next   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                cmd_err_next = bus.RX_d_valid;
                if (bus.RdData_valid) begin
                    tx_buf_next                 = '0;
                    tx_buf_next[Data_width-1:0] = bus.Rd_data;
                    tx_cnt_next                 = 3'd1;
                    state_next                  = TX_SEND;
                end
            end
            // Operands A and B land in registers 0 and 1 before the function byte.
            ALU_A: begin
                if (bus.RX_d_valid) begin
                    address_next = '0;
                    wr_en_next   = 1'b1;
                    wr_data_next = bus.RX_p_data;
                    state_next   = ALU_B;
                end
            end
            ALU_B: begin
                if (bus.RX_d_valid) begin
                    address_next = Address_width'(1);
                    wr_en_next   = 1'b1;
                    wr_data_next = bus.RX_p_data;
                    state_next   = ALU_FUN;
                end
            end
            ALU_FUN: begin
                if (bus.RX_d_valid) begin
                    alu_fun_next = bus.RX_p_data[3:0];
                    alu_en_next  = 1'b1;
                    clk_en_next  = 1'b1;
                    state_next   = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                cmd_err_next = bus.RX_d_valid;
                if (bus.OUT_VALID) begin
                    clk_en_next = 1'b0;
                    tx_buf_next = bus.ALU_OUT;
                    tx_cnt_next = 3'(ALU_OUT_BYTES);
                    state_next  = TX_SEND;
                end
            end
            // Bytes leave LSB-first; a full FIFO simply stalls the shift.
            TX_SEND: begin
                cmd_err_next = bus.RX_d_valid;
                if (tx_fire) begin
                    tx_buf_next = tx_buf_reg >> Data_width;
                    tx_cnt_next = tx_cnt_reg - 3'd1;
                    if (tx_cnt_reg == 3'd1) begin
                        state_next = IDLE;
`ifdef CMD_FRAME_BURST_EN
                        if (burst_rd_reg && (burst_cnt_reg != '0)) begin
                            address_next = address_reg + Address_width'(1);
                            rd_en_next   = 1'b1;
                            state_next   = BR_ISSUE;
                        end else begin
                            burst_rd_next = 1'b0;
                        end
`endif
                    end
                end
            end
`ifdef CMD_FRAME_BURST_EN
            BR_ADDR: begin
                if (bus.RX_d_valid) begin
                    address_next = bus.RX_p_data[Address_width-1:0];
                    state_next   = BR_LEN;
                end
            end
            BR_LEN: begin
                if (bus.RX_d_valid) begin
                    burst_cnt_next = bus.RX_p_data;
                    first_next     = 1'b1;
                    if (bus.RX_p_data == '0) begin
                        state_next = IDLE;
                    end else if (burst_wr_reg) begin
                        state_next = BW_DATA;
                    end else begin
                        rd_en_next    = 1'b1;
                        burst_rd_next = 1'b1;
                        state_next    = BR_ISSUE;
                    end
                end
            end
            // The first burst write uses the latched address; later ones step it first.
            BW_DATA: begin
                if (bus.RX_d_valid) begin
                    wr_en_next     = 1'b1;
                    wr_data_next   = bus.RX_p_data;
                    first_next     = 1'b0;
                    burst_cnt_next = burst_cnt_reg - Data_width'(1);
                    if (!first_reg) begin
                        address_next = address_reg + Address_width'(1);
                    end
                    if (burst_cnt_reg == Data_width'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            BR_ISSUE: begin
                cmd_err_next = bus.RX_d_valid;
                if (bus.RdData_valid) begin
                    tx_buf_next                 = '0;
                    tx_buf_next[Data_width-1:0] = bus.Rd_data;
                    tx_cnt_next                 = 3'd1;
                    burst_cnt_next              = burst_cnt_reg - Data_width'(1);
                    state_next                  = TX_SEND;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    assign bus.ALU_EN     = alu_en_reg;
    assign bus.ALU_FUN    = alu_fun_reg;
    assign bus.CLK_EN     = clk_en_reg;
    assign bus.Address    = address_reg;
    assign bus.WrEN       = wr_en_reg;
    assign bus.RdEN       = rd_en_reg;
    assign bus.WrData     = wr_data_reg;
    assign bus.TX_p_data  = (state_reg == TX_SEND) ? tx_buf_reg[Data_width-1:0] : '0;
    assign bus.TX_d_valid = tx_fire;
    assign bus.clk_div_en = 1'b1;
    assign bus.cmd_err    = cmd_err_reg;
endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// Scoreboard bench for cmd_frame_ctrl: stimulus pushes expected strobes/bytes, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_cmd_frame_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NB = 2;
`ifdef CMD_FRAME_BURST_EN
    localparam int NTYPES = 7;
`else
    localparam int NTYPES = 5;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cmd_frame_ctrl_if #(.Data_width(DW), .Address_width(AW), .ALU_OUT_BYTES(NB)) bus();

    cmd_frame_ctrl #(.Data_width(DW), .Address_width(AW), .ALU_OUT_BYTES(NB)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0]    mem [16];
    logic [AW+DW-1:0] exp_wr_q [$];
    logic [AW-1:0]    exp_rd_q [$];
    logic [DW-1:0]    exp_tx_q [$];
    logic [3:0]       exp_alu_q [$];
    bit               exp_err_q [$];
    logic [NB*DW-1:0] alu_res_q [$];

    bit rx_is_fun  = 1'b0;
    bit fifo_force = 1'b0;
    bit fun_prev   = 1'b0;
    bit clk_active = 1'b0;
    bit exp_alu_en;

    logic [AW+DW-1:0] wr_e;
    logic [AW-1:0]    rd_e;
    logic [DW-1:0]    tx_e;
    logic [3:0]       fun_e;
    logic [AW-1:0]    rd_resp_addr;
    int               rd_resp_dly;
    logic [NB*DW-1:0] alu_resp_val;
    int               alu_resp_dly;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=0x%0h required=no_event", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- environment responders ----------------
    initial begin
        bus.FIFO_full = 1'b0;
        forever begin
            tick();
            bus.FIFO_full = fifo_force ? 1'b1 : ($urandom_range(0, 99) < 30);
        end
    end

    initial begin
        bus.RdData_valid = 1'b0;
        bus.Rd_data      = '0;
        forever begin
            @(negedge clk);
            if (rst && bus.RdEN) begin
                rd_resp_addr = bus.Address;
                rd_resp_dly  = $urandom_range(0, 3);
                tick();
                repeat (rd_resp_dly) tick();
                bus.Rd_data      = mem[rd_resp_addr];
                bus.RdData_valid = 1'b1;
                tick();
                bus.RdData_valid = 1'b0;
            end
        end
    end

    initial begin
        bus.OUT_VALID = 1'b0;
        bus.ALU_OUT   = '0;
        forever begin
            @(negedge clk);
            if (rst && bus.ALU_EN) begin
                alu_resp_val = (alu_res_q.size() > 0) ? alu_res_q.pop_front() : '0;
                alu_resp_dly = $urandom_range(0, 3);
                tick();
                repeat (alu_resp_dly) tick();
                bus.ALU_OUT   = alu_resp_val;
                bus.OUT_VALID = 1'b1;
                tick();
                bus.OUT_VALID = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            fun_prev   = 1'b0;
            clk_active = 1'b0;
        end else begin
            exp_alu_en = fun_prev;
            if (exp_alu_en) clk_active = 1'b1;
            if (exp_alu_en || bus.ALU_EN) begin
                chk("alu_en", 32'(bus.ALU_EN), 32'(exp_alu_en));
                if (exp_alu_en && exp_alu_q.size() > 0) begin
                    fun_e = exp_alu_q.pop_front();
                    chk("alu_fun", 32'(bus.ALU_FUN), 32'(fun_e));
                    $display("%0t ALU start fun=%0h", $time, bus.ALU_FUN);
                end
            end
            if (clk_active || bus.CLK_EN) chk("clk_en", 32'(bus.CLK_EN), 32'(clk_active));
            if (bus.OUT_VALID) clk_active = 1'b0;
            fun_prev = bus.RX_d_valid && rx_is_fun;

            if (bus.WrEN) begin
                if (exp_wr_q.size() == 0) unexpected("wr_en", {bus.Address, bus.WrData});
                else begin
                    wr_e = exp_wr_q.pop_front();
                    chk("wr_addr", 32'(bus.Address), 32'(wr_e[AW+DW-1:DW]));
                    chk("wr_data", 32'(bus.WrData), 32'(wr_e[DW-1:0]));
                    $display("%0t WR addr=%0d data=%02h", $time, bus.Address, bus.WrData);
                end
            end
            if (bus.RdEN) begin
                if (exp_rd_q.size() == 0) unexpected("rd_en", 32'(bus.Address));
                else begin
                    rd_e = exp_rd_q.pop_front();
                    chk("rd_addr", 32'(bus.Address), 32'(rd_e));
                    $display("%0t RD addr=%0d", $time, bus.Address);
                end
            end
            if (bus.TX_d_valid) begin
                chk("tx_fifo_full", 32'(bus.FIFO_full), 32'd0);
                if (exp_tx_q.size() == 0) unexpected("tx_valid", 32'(bus.TX_p_data));
                else begin
                    tx_e = exp_tx_q.pop_front();
                    chk("tx_data", 32'(bus.TX_p_data), 32'(tx_e));
                    $display("%0t TX data=%02h", $time, bus.TX_p_data);
                end
            end
            if (bus.cmd_err) begin
                checks++;
                if (exp_err_q.size() == 0) begin
                    failures++;
                    $display("FAIL cmd_err actual=1 required=0");
                end else begin
                    void'(exp_err_q.pop_front());
                    $display("%0t ERR pulse", $time);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic int rgap();
        return int'($urandom_range(0, 2));
    endfunction

    function automatic bit is_opcode(input logic [DW-1:0] b);
        bit r;
        r = (b == 8'hAA) || (b == 8'hBB) || (b == 8'hCC) || (b == 8'hDD);
`ifdef CMD_FRAME_BURST_EN
        r = r || (b == 8'hEE) || (b == 8'hEF);
`endif
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_unknown();
        logic [DW-1:0] b;
        b = DW'($urandom);
        while (is_opcode(b)) b = DW'($urandom);
        return b;
    endfunction

    task automatic send_byte(input logic [DW-1:0] b, input bit is_fun, input int gap);
        bus.RX_p_data  = b;
        bus.RX_d_valid = 1'b1;
        rx_is_fun      = is_fun;
        tick();
        bus.RX_d_valid = 1'b0;
        rx_is_fun      = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_tx_q.size() + exp_wr_q.size() + exp_rd_q.size() + exp_err_q.size()
                + exp_alu_q.size()) != 0 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL frame_timeout actual=pending(tx=%0d wr=%0d rd=%0d err=%0d alu=%0d) required=drained",
                     exp_tx_q.size(), exp_wr_q.size(), exp_rd_q.size(), exp_err_q.size(), exp_alu_q.size());
            exp_tx_q.delete(); exp_wr_q.delete(); exp_rd_q.delete();
            exp_err_q.delete(); exp_alu_q.delete(); alu_res_q.delete();
        end
        tick();
    endtask

    task automatic do_write(input logic [DW-1:0] a, input logic [DW-1:0] d);
        exp_wr_q.push_back({a[AW-1:0], d});
        send_byte(8'hAA, 1'b0, rgap());
        send_byte(a, 1'b0, rgap());
        send_byte(d, 1'b0, 0);
        wait_idle();
    endtask

    task automatic do_read(input logic [DW-1:0] a);
        exp_rd_q.push_back(a[AW-1:0]);
        exp_tx_q.push_back(mem[a[AW-1:0]]);
        send_byte(8'hBB, 1'b0, rgap());
        send_byte(a, 1'b0, 0);
        wait_idle();
    endtask

    task automatic do_alu(input bit with_ops, input logic [DW-1:0] opa, input logic [DW-1:0] opb,
                          input logic [DW-1:0] fun, input logic [NB*DW-1:0] res);
        if (with_ops) begin
            exp_wr_q.push_back({AW'(0), opa});
            exp_wr_q.push_back({AW'(1), opb});
        end
        exp_alu_q.push_back(fun[3:0]);
        alu_res_q.push_back(res);
        for (int i = 0; i < NB; i++) exp_tx_q.push_back(res[i*DW +: DW]);
        send_byte(with_ops ? 8'hCC : 8'hDD, 1'b0, rgap());
        if (with_ops) begin
            send_byte(opa, 1'b0, rgap());
            send_byte(opb, 1'b0, rgap());
        end
        send_byte(fun, 1'b1, 0);
        wait_idle();
    endtask

    task automatic do_unknown(input logic [DW-1:0] op);
        exp_err_q.push_back(1'b1);
        send_byte(op, 1'b0, 0);
        wait_idle();
    endtask

`ifdef CMD_FRAME_BURST_EN
    task automatic do_burst(input bit wr, input logic [DW-1:0] a, input int n);
        logic [AW-1:0] ad;
        logic [DW-1:0] d;
        send_byte(wr ? 8'hEE : 8'hEF, 1'b0, rgap());
        send_byte(a, 1'b0, rgap());
        for (int i = 0; i < n; i++) begin
            ad = a[AW-1:0] + AW'(i);
            if (!wr) begin
                exp_rd_q.push_back(ad);
                exp_tx_q.push_back(mem[ad]);
            end
        end
        send_byte(DW'(n), 1'b0, wr ? rgap() : 0);
        if (wr) begin
            for (int i = 0; i < n; i++) begin
                ad = a[AW-1:0] + AW'(i);
                d  = DW'($urandom);
                exp_wr_q.push_back({ad, d});
                send_byte(d, 1'b0, rgap());
            end
        end
        wait_idle();
    endtask
`endif

    task automatic check_reset(input string tag);
        chk({tag, "_alu_en"},     32'(bus.ALU_EN), 32'd0);
        chk({tag, "_alu_fun"},    32'(bus.ALU_FUN), 32'd0);
        chk({tag, "_clk_en"},     32'(bus.CLK_EN), 32'd0);
        chk({tag, "_address"},    32'(bus.Address), 32'd0);
        chk({tag, "_wr_en"},      32'(bus.WrEN), 32'd0);
        chk({tag, "_rd_en"},      32'(bus.RdEN), 32'd0);
        chk({tag, "_wr_data"},    32'(bus.WrData), 32'd0);
        chk({tag, "_tx_data"},    32'(bus.TX_p_data), 32'd0);
        chk({tag, "_tx_valid"},   32'(bus.TX_d_valid), 32'd0);
        chk({tag, "_cmd_err"},    32'(bus.cmd_err), 32'd0);
        chk({tag, "_clk_div_en"}, 32'(bus.clk_div_en), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
        mem[3]         = 8'h7E;
        bus.RX_p_data  = '0;
        bus.RX_d_valid = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        tick();
        rst = 1'b1;
        tick();

        do_write(8'h05, 8'h3C);
        do_alu(1'b1, 8'h10, 8'h20, 8'h00, 16'h0030);

        // Read held behind a full FIFO: the byte must stay pending until space returns.
        fifo_force = 1'b1;
        exp_rd_q.push_back(4'd3);
        exp_tx_q.push_back(8'h7E);
        send_byte(8'hBB, 1'b0, 0);
        send_byte(8'h03, 1'b0, 0);
        repeat (8) tick();
        chk("tx_held_while_full", 32'(exp_tx_q.size()), 32'd1);
        fifo_force = 1'b0;
        wait_idle();

        do_unknown(8'h55);
`ifdef CMD_FRAME_BURST_EN
        do_burst(1'b0, 8'h0E, 3);
        do_burst(1'b1, 8'h0F, 3);
        do_burst(1'b1, 8'h02, 0);
        do_burst(1'b0, 8'h07, 0);
`else
        do_unknown(8'hEE);
        do_unknown(8'hEF);
`endif

        // Bytes arriving while the controller is busy are dropped with an error pulse.
        exp_rd_q.push_back(4'd9);
        exp_tx_q.push_back(mem[9]);
        exp_err_q.push_back(1'b1);
        send_byte(8'hBB, 1'b0, 0);
        send_byte(8'h09, 1'b0, 0);
        send_byte(8'hAA, 1'b0, 0);
        wait_idle();

        exp_alu_q.push_back(4'h7);
        alu_res_q.push_back(16'hBEEF);
        exp_tx_q.push_back(8'hEF);
        exp_tx_q.push_back(8'hBE);
        exp_err_q.push_back(1'b1);
        send_byte(8'hDD, 1'b0, 0);
        send_byte(8'h47, 1'b1, 0);
        send_byte(8'hCC, 1'b0, 0);
        wait_idle();

        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, NTYPES - 1))
                0: do_write(DW'($urandom), DW'($urandom));
                1: do_read(DW'($urandom));
                2: do_alu(1'b1, DW'($urandom), DW'($urandom), DW'($urandom), (NB*DW)'($urandom));
                3: do_alu(1'b0, '0, '0, DW'($urandom), (NB*DW)'($urandom));
                4: do_unknown(rand_unknown());
`ifdef CMD_FRAME_BURST_EN
                5: do_burst(1'b1, DW'($urandom), int'($urandom_range(0, 5)));
                6: do_burst(1'b0, DW'($urandom), int'($urandom_range(0, 5)));
`endif
                default: do_unknown(rand_unknown());
            endcase
        end

        // Reset in the middle of a frame: outputs clear at once and the frame is abandoned.
`ifdef CMD_FRAME_BURST_EN
        exp_wr_q.push_back({4'd6, 8'hA1});
        exp_wr_q.push_back({4'd7, 8'hB2});
        send_byte(8'hEE, 1'b0, 0);
        send_byte(8'h06, 1'b0, 0);
        send_byte(8'h04, 1'b0, 0);
        send_byte(8'hA1, 1'b0, 0);
        send_byte(8'hB2, 1'b0, 0);
`else
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'h06, 1'b0, 0);
`endif
        repeat (3) tick();
        chk("pre_reset_writes_seen", 32'(exp_wr_q.size()), 32'd0);
        rst = 1'b0;
        #2;
        check_reset("midframe_reset");
        tick();
        tick();
        rst = 1'b1;
        repeat (10) tick();
        do_write(8'h0B, 8'h5A);
        do_read(8'h0B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
